rtc_bcd_core: RTL and testbench



---
 rtl/rtc_bcd_core.sv | 75 +++++++
 tb/tb_rtc_bcd_core.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rtc_bcd_core.sv
// rtc_bcd_core: 1 Hz BCD clock (hh:mm:ss) with mode/inc time set; CLOCK_12H_EN selects 12-hour mode with pm_led
module rtc_bcd_core #(
  parameter int CLK_HZ = 50000000,
  parameter int PRESCALE_W = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [7:0] clock_out,
  output logic       dp_led,
  output logic [7:0] hours_bcd,
  output logic [7:0] minutes_bcd,
  output logic [7:0] seconds_bcd,
  output logic       sec_tick,
  output logic [1:0] set_mode,
  output logic       pm_led
);
  typedef enum logic [1:0] {RUN = 2'b00, SET_HR = 2'b01, SET_MIN = 2'b10} mode_t;
`ifdef CLOCK_12H_EN
  localparam bit H12 = 1'b1;
`else
  localparam bit H12 = 1'b0;
`endif
  localparam logic [7:0] HR_RST = H12 ? 8'h12 : 8'h00;
  mode_t state, state_nx;
  logic [PRESCALE_W-1:0] presc;
  logic mode_q, inc_q, mode_e, inc_e, tick, hr_step, dp_nx, pm_nx;
  logic [7:0] hr_nx, min_nx, sec_nx;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    return v == top ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
  function automatic logic [7:0] hr_inc(input logic [7:0] v);
    return H12 ? (v == 8'h12 ? 8'h01 : bcd_inc(v, 8'h12)) : bcd_inc(v, 8'h23);
  endfunction
  assign mode_e = mode_btn & ~mode_q;
  assign inc_e = inc_btn & ~inc_q & ~mode_e;
  assign tick = state == RUN && presc == PRESCALE_W'(CLK_HZ - 1);
  assign clock_out = {hours_bcd[3:0], minutes_bcd[3:0]};
  assign set_mode = state;
  assign hr_step = (tick && seconds_bcd == 8'h59 && minutes_bcd == 8'h59) || (inc_e && state == SET_HR);
  always_comb begin
    state_nx = !mode_e ? state : state == RUN ? SET_HR : state == SET_HR ? SET_MIN : RUN;
    sec_nx = tick ? bcd_inc(seconds_bcd, 8'h59) : mode_e && state == SET_MIN ? 8'h00 : seconds_bcd;
    min_nx = (tick && seconds_bcd == 8'h59) || (inc_e && state == SET_MIN) ? bcd_inc(minutes_bcd, 8'h59) : minutes_bcd;
    hr_nx = hr_step ? hr_inc(hours_bcd) : hours_bcd;
    pm_nx = pm_led ^ (hr_step && H12 && hours_bcd == 8'h11);
    dp_nx = state_nx != RUN ? 1'b1 : state != RUN ? 1'b0 : dp_led ^ tick;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      presc <= '0;
      hours_bcd <= HR_RST;
      minutes_bcd <= 8'h00;
      seconds_bcd <= 8'h00;
      pm_led <= 1'b0;
      dp_led <= 1'b0;
      sec_tick <= 1'b0;
      mode_q <= 1'b1;
      inc_q <= 1'b1;
    end else begin
      state <= state_nx;
      presc <= state != RUN || tick ? '0 : presc + PRESCALE_W'(1);
      hours_bcd <= hr_nx;
      minutes_bcd <= min_nx;
      seconds_bcd <= sec_nx;
      pm_led <= pm_nx;
      dp_led <= dp_nx;
      sec_tick <= tick;
      mode_q <= mode_btn;
      inc_q <= inc_btn;
    end
  end
endmodule

// File: tb/tb_rtc_bcd_core.sv
// tb_rtc_bcd_core: table vectors, corner sequences and random buttons checked against an integer clock model
module tb_rtc_bcd_core;
  localparam int CLK_HZ = 4;
`ifdef CLOCK_12H_EN
  localparam bit H12 = 1'b1;
`else
  localparam bit H12 = 1'b0;
`endif
  localparam int HR0 = H12 ? 'h12 : 'h00;
  logic clk = 1'b0, rst_n = 1'b0, mode_btn = 1'b0, inc_btn = 1'b0;
  logic [7:0] clock_out, hours_bcd, minutes_bcd, seconds_bcd;
  logic dp_led, sec_tick, pm_led;
  logic [1:0] set_mode;
  int checks = 0, failures = 0;
  int md, pc, h, mi, s;
  bit dp, pm, stk, mq, iq;
  typedef struct {bit r; bit m; bit i; int md; int hr; int mi; int sec; bit dp;} vec_t;
  vec_t tbl[14];
  rtc_bcd_core #(.CLK_HZ(CLK_HZ), .PRESCALE_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .clock_out(clock_out), .dp_led(dp_led), .hours_bcd(hours_bcd),
    .minutes_bcd(minutes_bcd), .seconds_bcd(seconds_bcd), .sec_tick(sec_tick),
    .set_mode(set_mode), .pm_led(pm_led)
  );
  always #5 clk = ~clk;
  function automatic int bcd(input int v);
    return (v / 10) * 16 + v % 10;
  endfunction
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask
  task automatic hr_adv();
    if (H12) begin
      if (h == 11) pm = ~pm;
      h = h % 12 + 1;
    end else h = (h + 1) % 24;
  endtask
  task automatic model_step(input bit r, input bit m, input bit i);
    bit me, ie, tk;
    int old;
    if (!r) begin
      md = 0; pc = 0; h = H12 ? 12 : 0; mi = 0; s = 0;
      dp = 0; pm = 0; stk = 0; mq = 1; iq = 1;
    end else begin
      me = m && !mq;
      ie = i && !iq && !me;
      mq = m;
      iq = i;
      tk = md == 0 && pc == CLK_HZ - 1;
      pc = (md != 0 || tk) ? 0 : pc + 1;
      if (tk) begin
        s = (s + 1) % 60;
        if (s == 0) begin
          mi = (mi + 1) % 60;
          if (mi == 0) hr_adv();
        end
      end
      old = md;
      if (me) begin
        if (md == 2) s = 0;
        md = (md + 1) % 3;
      end else if (ie && md == 1) hr_adv();
      else if (ie && md == 2) mi = (mi + 1) % 60;
      dp = md != 0 ? 1'b1 : old != 0 ? 1'b0 : dp ^ tk;
      stk = tk;
    end
  endtask
  task automatic compare_all();
    chk("hours", hours_bcd, bcd(h));
    chk("minutes", minutes_bcd, bcd(mi));
    chk("seconds", seconds_bcd, bcd(s));
    chk("clock_out", clock_out, ((bcd(h) & 15) << 4) | (bcd(mi) & 15));
    chk("dp_led", dp_led, dp);
    chk("sec_tick", sec_tick, stk);
    chk("set_mode", set_mode, md);
    chk("pm_led", pm_led, pm);
  endtask
  task automatic cyc(input bit r, input bit m, input bit i);
    rst_n = r;
    mode_btn = m;
    inc_btn = i;
    @(posedge clk);
    model_step(r, m, i);
    #1;
    compare_all();
  endtask
  task automatic press_mode();
    cyc(1, 1, 0);
    cyc(1, 0, 0);
  endtask
  task automatic press_inc();
    cyc(1, 0, 1);
    cyc(1, 0, 0);
  endtask
  task automatic do_reset();
    cyc(0, 0, 0);
    cyc(1, 0, 0);
  endtask
  task automatic preload_wrap(input int n_hr, input int exp_hr, input int exp_pm);
    press_mode();
    repeat (n_hr) press_inc();
    press_mode();
    repeat (59) press_inc();
    press_mode();
    chk("preload_sec", seconds_bcd, 0);
    for (int t = 1; t <= 60; t++) begin
      int n = 0;
      do begin
        cyc(1, 0, 0);
        n++;
      end while (!sec_tick && n < 8);
      chk("tick_seen", sec_tick, 1);
      if (t == 59) begin
        chk("pre_wrap_min", minutes_bcd, 'h59);
        chk("pre_wrap_sec", seconds_bcd, 'h59);
      end
    end
    chk("wrap_hr", hours_bcd, exp_hr);
    chk("wrap_min", minutes_bcd, 0);
    chk("wrap_sec", seconds_bcd, 0);
    chk("wrap_clock_out", clock_out, (exp_hr & 15) << 4);
    chk("wrap_pm", pm_led, exp_pm);
  endtask
  initial begin
    tbl[0]  = '{0, 0, 0, 0, HR0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, HR0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 1, HR0, 0, 0, 1};
    tbl[3]  = '{1, 0, 1, 1, 'h01, 0, 0, 1};
    tbl[4]  = '{1, 0, 0, 1, 'h01, 0, 0, 1};
    tbl[5]  = '{1, 0, 1, 1, 'h02, 0, 0, 1};
    tbl[6]  = '{1, 0, 0, 1, 'h02, 0, 0, 1};
    tbl[7]  = '{1, 1, 1, 2, 'h02, 0, 0, 1};
    tbl[8]  = '{1, 0, 0, 2, 'h02, 0, 0, 1};
    tbl[9]  = '{1, 0, 1, 2, 'h02, 'h01, 0, 1};
    tbl[10] = '{1, 0, 0, 2, 'h02, 'h01, 0, 1};
    tbl[11] = '{0, 1, 1, 0, HR0, 0, 0, 0};
    tbl[12] = '{1, 1, 1, 0, HR0, 0, 0, 0};
    tbl[13] = '{1, 0, 0, 0, HR0, 0, 0, 0};
    cyc(0, 0, 0);
    chk("reset_hours", hours_bcd, HR0);
    chk("reset_clock_out", clock_out, (HR0 & 15) << 4);
    begin
      int n = 0;
      do begin
        cyc(1, 0, 0);
        n++;
      end while (!sec_tick && n < 10);
      chk("first_tick_latency", n, CLK_HZ);
      chk("first_tick_sec", seconds_bcd, 'h01);
      chk("first_tick_dp", dp_led, 1);
      repeat (CLK_HZ) cyc(1, 0, 0);
      chk("second_tick", sec_tick, 1);
      chk("second_tick_sec", seconds_bcd, 'h02);
      chk("second_tick_dp", dp_led, 0);
    end
    for (int k = 0; k < 14; k++) begin
      cyc(tbl[k].r, tbl[k].m, tbl[k].i);
      chk($sformatf("tbl%0d_mode", k), set_mode, tbl[k].md);
      chk($sformatf("tbl%0d_hr", k), hours_bcd, tbl[k].hr);
      chk($sformatf("tbl%0d_min", k), minutes_bcd, tbl[k].mi);
      chk($sformatf("tbl%0d_sec", k), seconds_bcd, tbl[k].sec);
      chk($sformatf("tbl%0d_dp", k), dp_led, tbl[k].dp);
    end
    do_reset();
    press_mode();
    repeat (5) press_inc();
    chk("set_hr_mode", set_mode, 1);
    chk("set_hr_val", hours_bcd, 'h05);
    press_mode();
    repeat (61) press_inc();
    chk("set_min_val", minutes_bcd, 'h01);
    chk("set_min_hr", hours_bcd, 'h05);
    press_mode();
    chk("exit_mode", set_mode, 0);
    chk("exit_sec", seconds_bcd, 0);
    chk("exit_dp", dp_led, 0);
    do_reset();
    if (H12) begin
      preload_wrap(11, 'h12, 1);
      preload_wrap(0, 'h01, 1);
    end else preload_wrap(23, 'h00, 0);
    do_reset();
    for (int k = 0; k < 4000; k++)
      cyc($urandom_range(0, 299) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
